// File: rtl/lut_ff_slice_pkg.sv
// Shared types and helpers for the programmable LUT/FF slice.
package lut_ff_slice_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    ERR    = 2'd3
  } cfg_state_t;

  function automatic int cfg_width(input int k, input int n);
    return n * (1 << k);
  endfunction

endpackage

// File: rtl/lut_ff_cell.sv
// One slice channel: K-input LUT select, capture FF with clock enable, output mux.
module lut_ff_cell
  import lut_ff_slice_pkg::*;
#(
  parameter int K = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            sel,
  input  logic [K-1:0]    idx,
  input  logic [2**K-1:0] tbl,
  output logic            q
);

  logic lut_p0;
  logic ff_p1;

  // stage p0: combinational table lookup
  assign lut_p0 = tbl[idx];

  // stage p1: capture register
  always_ff @(posedge clk) begin
    if (rst)     ff_p1 <= 1'b0;
    else if (ce) ff_p1 <= lut_p0;
  end

  assign q = rst ? 1'b0 : (sel ? ff_p1 : lut_p0);

endmodule

// File: rtl/lut_ff_slice.sv
// N_CH-channel programmable LUT/FF slice with serial shadow-and-commit table loading.
// Define LUT_FF_SLICE_READBACK_EN to add cfg_rdata, which shifts out the previous table during a load.
module lut_ff_slice
  import lut_ff_slice_pkg::*;
#(
  parameter int                      K    = 4,
  parameter int                      N_CH = 2,
  parameter logic [N_CH*(2**K)-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*K-1:0] in,
  input  logic              ce,
  input  logic [N_CH-1:0]   mux_sel,
  output logic [N_CH-1:0]   Q,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_bit,
  input  logic              cfg_last,
  output logic              cfg_done,
  output logic              cfg_err
`ifdef LUT_FF_SLICE_READBACK_EN
  ,
  output logic              cfg_rdata
`endif
);

  localparam int TBL_W = 1 << K;
  localparam int CFG_W = cfg_width(K, N_CH);
  localparam int CNT_W = $clog2(CFG_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W - 1);

  cfg_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             err_nx;
  logic             accept;
  logic [CFG_W-1:0] active;
  logic [CFG_W-1:0] shadow;
  logic [CFG_W-1:0] shadow_base;

  assign cfg_ready = !rst && (state != COMMIT);
  assign cfg_done  = !rst && (state == COMMIT);
  assign accept    = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cfg_err <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = cfg_err;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cfg_last) begin
            err_nx = 1'b1;
          end else begin
            state_nx = LOAD;
            cnt_nx   = CNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (cfg_last) begin
            if (cnt == CNT_MAX) begin
              state_nx = COMMIT;
            end else begin
              state_nx = IDLE;
              err_nx   = 1'b1;
            end
          end else if (cnt == CNT_MAX) begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        state_nx = IDLE;
        err_nx   = 1'b0;
      end
      ERR: begin
        if (accept && cfg_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // With readback, an idle shadow mirrors the active table so a load shifts it out.
  always_comb begin
`ifdef LUT_FF_SLICE_READBACK_EN
    shadow_base = (state == IDLE) ? active : shadow;
`else
    shadow_base = shadow;
`endif
  end

  always_ff @(posedge clk) begin
    if (accept && (state == IDLE || state == LOAD))
      shadow <= {cfg_bit, shadow_base[CFG_W-1:1]};
    else
      shadow <= shadow_base;
  end

  always_ff @(posedge clk) begin
    if (rst)                  active <= INIT;
    else if (state == COMMIT) active <= shadow;
  end

`ifdef LUT_FF_SLICE_READBACK_EN
  assign cfg_rdata = shadow[0];
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lut_ff_cell #(.K(K)) u_cell (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .sel (mux_sel[c]),
      .idx (in[c*K +: K]),
      .tbl (active[c*TBL_W +: TBL_W]),
      .q   (Q[c])
    );
  end

endmodule

// File: tb/tb_lut_ff_slice.sv
// Directed + randomized bench for lut_ff_slice (K=4, N_CH=2, INIT=0) against a table-lookup model.
module tb_lut_ff_slice;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_v;
  logic       ce;
  logic [1:0] mux_sel;
  logic [1:0] Q;
  logic       cfg_valid, cfg_ready, cfg_bit, cfg_last, cfg_done, cfg_err;
`ifdef LUT_FF_SLICE_READBACK_EN
  logic       cfg_rdata;
`endif

  int nerr = 0;
  int nchecks = 0;
  int done_cnt = 0;

  lut_ff_slice #(.K(4), .N_CH(2), .INIT('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_v),
    .ce        (ce),
    .mux_sel   (mux_sel),
    .Q         (Q),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_bit   (cfg_bit),
    .cfg_last  (cfg_last),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
`ifdef LUT_FF_SLICE_READBACK_EN
    ,
    .cfg_rdata (cfg_rdata)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_done === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel c output for input byte i under table t: t[c*16 + nibble_c].
  function automatic logic [1:0] lut_ref(input logic [31:0] t, input logic [7:0] i);
    lut_ref[0] = t[int'(i[3:0])];
    lut_ref[1] = t[16 + int'(i[7:4])];
  endfunction

  task automatic send_bit(input logic b, input logic last);
    int guard = 0;
    cfg_valid = 1'b1;
    cfg_bit   = b;
    cfg_last  = last;
    #1;
    while (cfg_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("ready_wait_timeout", (guard < 20), 1);
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] d, input int n, input bit with_last);
    for (int i = 0; i < n; i++) send_bit(d[i], with_last && (i == n - 1));
  endtask

  // Full 32-bit load; checks the COMMIT cycle (Q still under the old table) and the single done pulse.
  task automatic full_load(input string tag, input logic [31:0] t, input logic [1:0] q_old);
    int d0;
    d0 = done_cnt;
    send_bits({32'h0, t}, 32, 1'b1);
    #1;
    chk({tag, "_commit_done"}, cfg_done, 1);
    chk({tag, "_commit_ready"}, cfg_ready, 0);
    chk({tag, "_commit_q_old"}, Q, q_old);
    tick();
    chk({tag, "_done_once"}, done_cnt, d0 + 1);
    chk({tag, "_done_low"}, cfg_done, 0);
    chk({tag, "_err_clear"}, cfg_err, 0);
  endtask

  task automatic scan_table(input string tag, input logic [31:0] t);
    mux_sel = 2'b00;
    for (int v = 0; v < 16; v++) begin
      in_v = {v[3:0], v[3:0]};
      #1;
      chk(tag, Q, lut_ref(t, in_v));
    end
  endtask

  logic [31:0] tbl_a, tbl_b, tbl_c, tbl_d, tbl_r;
  logic [1:0]  mff;
  int          d_ref;

  initial begin
    tbl_a = {16'h8000, 16'h6996};
    tbl_b = $urandom;
    tbl_c = $urandom;
    tbl_d = $urandom;
    tbl_r = $urandom;

    rst = 1'b1; in_v = 8'hFF; ce = 1'b1; mux_sel = 2'b11;
    cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_last = 1'b0;

    // 1. reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_q", Q, 2'b00);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_done", cfg_done, 0);
    end
    rst = 1'b0;
    mux_sel = 2'b00;
    #1;
    chk("post_rst_q", Q, 2'b00);
    chk("post_rst_ready", cfg_ready, 1);
    chk("post_rst_err", cfg_err, 0);

    // 2. full load: parity / AND
    in_v = 8'hF3;
    full_load("load_a", tbl_a, 2'b00);
    chk("load_a_q", Q, 2'b10);
    mux_sel = 2'b11;
    #1;
    chk("ff_old_table_in_commit", Q, 2'b00);

    // 3. registered path
    ce = 1'b1; in_v = 8'hF1;
    tick();
    chk("reg_capture", Q, 2'b11);
    ce = 1'b0; in_v = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reg_hold", Q, 2'b11);
    end
    mux_sel = 2'b00;
    #1;
    chk("comb_switch", Q, 2'b00);

    // 4a. short load
    d_ref = done_cnt;
    send_bits({32'h0, tbl_b}, 20, 1'b1);
    #1;
    chk("short_err", cfg_err, 1);
    chk("short_idle_ready", cfg_ready, 1);
    in_v = 8'hF3; mux_sel = 2'b00;
    #1;
    chk("short_table_kept", Q, 2'b10);
    chk("short_no_done", done_cnt, d_ref);

    // 4b. overrun (reload tbl_a first so cfg_err starts clear)
    full_load("reload_a", tbl_a, 2'b10);
    d_ref = done_cnt;
    send_bits({32'h0, tbl_b}, 31, 1'b0);
    chk("overrun_err_before_32", cfg_err, 0);
    send_bit(tbl_b[31], 1'b0);
    #1;
    chk("overrun_err_at_32", cfg_err, 1);
    send_bit(1'b1, 1'b1);
    #1;
    chk("overrun_drained_ready", cfg_ready, 1);
    chk("overrun_err_sticky", cfg_err, 1);
    chk("overrun_table_kept", Q, 2'b10);
    chk("overrun_no_done", done_cnt, d_ref);

    // 5. reset mid-load
    send_bits({32'h0, tbl_b}, 10, 1'b0);
    rst = 1'b1;
    in_v = 8'($urandom); mux_sel = 2'($urandom);
    #1;
    chk("midrst_q", Q, 2'b00);
    chk("midrst_ready", cfg_ready, 0);
    tick();
    chk("midrst_err", cfg_err, 0);
    chk("midrst_q2", Q, 2'b00);
    rst = 1'b0;
    in_v = 8'hF3; mux_sel = 2'b00;
    #1;
    chk("midrst_init_table", Q, 2'b00);
    full_load("load_b", tbl_b, 2'b00);
    for (int i = 0; i < 6; i++) begin
      in_v = 8'($urandom);
      #1;
      chk("load_b_q", Q, lut_ref(tbl_b, in_v));
    end

    // 6. backpressure across COMMIT
    in_v = 8'hF3; mux_sel = 2'b00;
    d_ref = done_cnt;
    send_bits({32'h0, tbl_c}, 32, 1'b1);
    cfg_valid = 1'b1; cfg_bit = tbl_d[0]; cfg_last = 1'b0;
    #1;
    chk("bp_ready_low", cfg_ready, 0);
    chk("bp_done_high", cfg_done, 1);
    tick();
    chk("bp_ready_idle", cfg_ready, 1);
    #1;
    chk("bp_table_c", Q, lut_ref(tbl_c, in_v));
    tick();
    cfg_valid = 1'b0;
    for (int i = 1; i < 32; i++) send_bit(tbl_d[i], i == 31);
    tick();
    chk("bp_two_done", done_cnt, d_ref + 2);
    scan_table("bp_table_d", tbl_d);

    // randomized datapath vs model
    full_load("load_r", tbl_r, lut_ref(tbl_d, in_v));
    ce = 1'b1; in_v = 8'($urandom);
    mff = lut_ref(tbl_r, in_v);
    tick();
    for (int i = 0; i < 60; i++) begin
      in_v = 8'($urandom); mux_sel = 2'($urandom); ce = 1'($urandom);
      #1;
      for (int c = 0; c < 2; c++)
        chk("rand_q", Q[c], mux_sel[c] ? mff[c] : lut_ref(tbl_r, in_v) >> c & 1);
      if (ce) mff = lut_ref(tbl_r, in_v);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
